arb_grant_mux: RTL and testbench

//  Multi-channel valid/ready front end and grant mux around the codebase round-robin

---
 rtl/arb_grant_mux.sv | 119 +++++++++++
 tb/tb_arb_grant_mux.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_grant_mux.sv
// Valid/ready front end and grant mux for a round-robin arbiter: one hold register per
// channel drives the arbiter's request vector, and the granted word goes to a registered output.
module arb_grant_mux #(
    parameter int REQ_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    localparam int SRC_W     = $clog2(REQ_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REQ_WIDTH-1:0]            in_valid,
    output logic [REQ_WIDTH-1:0]            in_ready,
    input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
    output logic [REQ_WIDTH-1:0]            req,
    input  logic [REQ_WIDTH-1:0]            gnt,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [SRC_W-1:0]                out_src,
    output logic                            err_gnt
);

    localparam logic [REQ_WIDTH-1:0] ONE_V  = {{(REQ_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REQ_WIDTH-1:0] ZERO_V = {REQ_WIDTH{1'b0}};

    function automatic logic is_onehot(input logic [REQ_WIDTH-1:0] v);
        return (v != ZERO_V) && ((v & (v - ONE_V)) == ZERO_V);
    endfunction

    function automatic logic [SRC_W-1:0] onehot_to_idx(input logic [REQ_WIDTH-1:0] v);
        logic [SRC_W-1:0] idx;
        idx = {SRC_W{1'b0}};
        for (int i = 0; i < REQ_WIDTH; i++) begin
            idx = idx | (v[i] ? SRC_W'(i) : {SRC_W{1'b0}});
        end
        return idx;
    endfunction

    logic [REQ_WIDTH-1:0]  hold_v_r;
    logic [DATA_WIDTH-1:0] hold_d_r [REQ_WIDTH];
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [SRC_W-1:0]      out_src_r;
    logic                  err_gnt_r;

    logic                  out_free_s;
    logic [REQ_WIDTH-1:0]  req_s;
    logic                  gnt_ok_s;
    logic                  take_s;
    logic                  illegal_s;
    logic [REQ_WIDTH-1:0]  sel_s;
    logic [REQ_WIDTH-1:0]  in_ready_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    // Request gating, grant validation and winner selection.
    // Requests are withheld while the output is stalled so the arbiter does not rotate.
    always_comb begin
        out_free_s = ~out_valid_r | out_ready;
        req_s      = hold_v_r & {REQ_WIDTH{out_free_s}};
        gnt_ok_s   = is_onehot(gnt) && ((gnt & ~req_s) == ZERO_V);
        take_s     = gnt_ok_s && (req_s != ZERO_V);
        illegal_s  = ((req_s != ZERO_V) && !gnt_ok_s) || ((req_s == ZERO_V) && (gnt != ZERO_V));
        sel_s      = gnt & {REQ_WIDTH{take_s}};
        in_ready_s = ~hold_v_r | sel_s;
        sel_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < REQ_WIDTH; i++) begin
            sel_data_s = sel_data_s | (hold_d_r[i] & {DATA_WIDTH{sel_s[i]}});
        end
    end

    // Per-channel hold registers: a load wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_r <= ZERO_V;
            for (int i = 0; i < REQ_WIDTH; i++) begin
                hold_d_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < REQ_WIDTH; i++) begin
                if (in_valid[i] && in_ready_s[i]) begin
                    hold_v_r[i] <= 1'b1;
                    hold_d_r[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (sel_s[i]) begin
                    hold_v_r[i] <= 1'b0;
                end else begin
                    hold_v_r[i] <= hold_v_r[i];
                end
            end
        end
    end

    // Output register and sticky illegal-grant flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_src_r   <= {SRC_W{1'b0}};
            err_gnt_r   <= 1'b0;
        end else begin
            err_gnt_r <= err_gnt_r | illegal_s;
            if (take_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sel_data_s;
                out_src_r   <= onehot_to_idx(sel_s);
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign req       = req_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign err_gnt   = err_gnt_r;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Bench for arb_grant_mux with a behavioural round-robin arbiter, a per-channel
// ordering scoreboard and directed scenarios for reset, bursts, stalls and bad grants.
module tb_arb_grant_mux;

    localparam int N = 8;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_src;
    logic           err_gnt;

    arb_grant_mux #(.REQ_WIDTH(N), .DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .req(req), .gnt(gnt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_src(out_src), .err_gnt(err_gnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;

    typedef struct { int cyc; logic [2:0] src; logic [W-1:0] data; } ent_t;
    ent_t sbq[$];
    ent_t olog[$];

    // Behavioural round-robin arbiter: search from ptr, advance past the winner on any request.
    logic [2:0]   ptr;
    logic [2:0]   gidx;
    logic [N-1:0] arb_gnt;
    logic         found;
    logic [2:0]   jj;
    logic         force_mode;
    logic [N-1:0] gnt_force;

    always_comb begin
        arb_gnt = '0;
        gidx    = ptr;
        found   = 1'b0;
        jj      = 3'd0;
        for (int k = 0; k < N; k++) begin
            jj = ptr + 3'(k);
            if (!found && req[jj]) begin
                found       = 1'b1;
                arb_gnt[jj] = 1'b1;
                gidx        = jj;
            end
        end
    end

    assign gnt = force_mode ? gnt_force : arb_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= 3'd0;
        else if (!force_mode && req != '0) ptr <= gidx + 3'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: records accepted input words and checks every output transfer against them.
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_data;
        logic [2:0]   prev_src;
        int           hit;
        ent_t         e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_src   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (in_valid[i] && in_ready[i]) begin
                        e.cyc = cyc; e.src = 3'(i); e.data = in_data[i*W +: W];
                        sbq.push_back(e);
                    end
                end
                if (prev_stall) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_data", 64'(out_data), 64'(prev_data));
                    check("stall_src", 64'(out_src), 64'(prev_src));
                end
                if (out_valid && !out_ready) check("stall_req", 64'(req), 64'd0);
                if (out_valid && out_ready) begin
                    hit = -1;
                    for (int q = 0; q < sbq.size(); q++) begin
                        if (hit < 0 && sbq[q].src == out_src) hit = q;
                    end
                    check("sb_present", 64'(hit >= 0), 64'd1);
                    if (hit >= 0) begin
                        check("sb_data", 64'(out_data), 64'(sbq[hit].data));
                        sbq.delete(hit);
                    end
                    e.cyc = cyc; e.src = out_src; e.data = out_data;
                    olog.push_back(e);
                    n_out++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_src   = out_src;
            end
        end
    end

    task automatic do_reset();
        in_valid = '0;
        rst_n    = 1'b0;
        sbq.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int n0;
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        force_mode = 1'b0;
        gnt_force  = '0;
        do_reset();

        // t1: idle after reset
        check("t1_in_ready", 64'(in_ready), 64'hFF);
        check("t1_req", 64'(req), 64'd0);
        check("t1_out_valid", 64'(out_valid), 64'd0);
        check("t1_out_src", 64'(out_src), 64'd0);
        check("t1_out_data", 64'(out_data), 64'd0);
        check("t1_err", 64'(err_gnt), 64'd0);

        // t2: all channels at once, two-cycle latency then one word per cycle in order
        out_ready = 1'b1;
        in_valid  = 8'hFF;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h100 + 32'(i);
        step();
        in_valid = '0;
        check("t2_lat_valid", 64'(out_valid), 64'd0);
        check("t2_req", 64'(req), 64'hFF);
        for (int k = 0; k < N; k++) begin
            step();
            check("t2_valid", 64'(out_valid), 64'd1);
            check("t2_src", 64'(out_src), 64'(k));
            check("t2_data", 64'(out_data), 64'h100 + 64'(k));
        end
        step();
        check("t2_end_valid", 64'(out_valid), 64'd0);

        // t3: stalled output must freeze data and priority, then resume in order
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h200 + 32'(i);
        step();
        in_valid = '0;
        step();
        check("t3_first_src", 64'(out_src), 64'd0);
        check("t3_first_data", 64'(out_data), 64'h200);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_stall_req", 64'(req), 64'd0);
            check("t3_stall_data", 64'(out_data), 64'h200);
            check("t3_stall_in_ready", 64'(in_ready), 64'h01);
        end
        out_ready = 1'b1;
        for (int k = 1; k < N; k++) begin
            step();
            check("t3_valid", 64'(out_valid), 64'd1);
            check("t3_src", 64'(out_src), 64'(k));
            check("t3_data", 64'(out_data), 64'h200 + 64'(k));
        end
        step();
        check("t3_end_valid", 64'(out_valid), 64'd0);

        // t4: single channel streams at full rate
        olog.delete();
        in_valid = 8'h08;
        for (int d = 1; d <= 4; d++) begin
            in_data[3*W +: W] = 32'(d);
            check("t4_in_ready", 64'(in_ready[3]), 64'd1);
            step();
        end
        in_valid = '0;
        repeat (4) step();
        check("t4_count", 64'(olog.size()), 64'd4);
        for (int q = 0; q < olog.size(); q++) begin
            check("t4_src", 64'(olog[q].src), 64'd3);
            check("t4_data", 64'(olog[q].data), 64'(q + 1));
            if (q > 0) check("t4_consecutive", 64'(olog[q].cyc - olog[q-1].cyc), 64'd1);
        end

        // t5: illegal grant from an external driver
        do_reset();
        force_mode = 1'b1;
        gnt_force  = '0;
        in_valid   = 8'h03;
        in_data[0 +: W] = 32'hA0;
        in_data[W +: W] = 32'hA1;
        step();
        in_valid  = '0;
        gnt_force = 8'h03;
        check("t5_req", 64'(req), 64'h03);
        check("t5_err_before", 64'(err_gnt), 64'd0);
        step();
        check("t5_err", 64'(err_gnt), 64'd1);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_hold", 64'(in_ready), 64'hFC);
        gnt_force = '0;
        step();
        check("t5_err_sticky", 64'(err_gnt), 64'd1);
        check("t5_out_valid2", 64'(out_valid), 64'd0);
        force_mode = 1'b0;
        do_reset();
        check("t5_err_cleared", 64'(err_gnt), 64'd0);

        // t6: reset in the middle of a burst discards everything
        out_ready = 1'b1;
        in_valid  = 8'hFF;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h300 + 32'(i);
        step();
        in_valid = '0;
        step();
        step();
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'hFF);
        check("t6_req", 64'(req), 64'd0);
        step();
        rst_n = 1'b1;
        n0 = n_out;
        repeat (15) step();
        check("t6_no_stale", 64'(n_out), 64'(n0));

        // Random traffic with random backpressure, then drain
        for (int c = 0; c < 400; c++) begin
            in_valid = 8'($urandom);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && sbq.size() != 0; c++) step();
        repeat (3) step();
        check("rnd_drained", 64'(sbq.size()), 64'd0);
        check("rnd_err", 64'(err_gnt), 64'd0);
        check("rnd_idle", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
